// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the pipeline and a
// long-latency unit, with a 2-entry result FIFO, RAW/WAW scoreboard and starvation hold.
`default_nettype none

module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_addr_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_addr_i,
  output logic        iss_ready_o,
  input  logic [4:0]  rd_addr1_i,
  input  logic [4:0]  rd_addr2_i,
  output logic        stall_o,
  output logic        hold_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_w_addr_o,
  output logic [31:0] rf_w_data_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [1:0]    cnt_q, cnt_d;
  logic [4:0]    addr0_q, addr0_d, addr1_q, addr1_d;
  logic [31:0]   data0_q, data0_d, data1_q, data1_d;
  logic [31:0]   pending_q, pending_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          hold_q, hold_d;
  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fifo_src_q, fifo_src_d;

  logic full, empty, push, pop;

  always_comb begin
    full  = (cnt_q == 2'd2);
    empty = (cnt_q == 2'd0);
    push  = mc_valid_i & ~full;
    pop   = ~pipe_we_i & ~empty;

    addr0_d    = addr0_q;
    data0_d    = data0_q;
    addr1_d    = addr1_q;
    data1_d    = data1_q;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
    pending_d  = pending_q;
    wait_d     = wait_q;
    hold_d     = hold_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    fifo_src_d = 1'b0;

    if (pop) begin
      addr0_d = addr1_q;
      data0_d = data1_q;
    end
    // A push lands in the head slot when the FIFO is, or is about to be, empty.
    if (push) begin
      if (empty || (pop && cnt_q == 2'd1)) begin
        addr0_d = mc_addr_i;
        data0_d = mc_data_i;
      end else begin
        addr1_d = mc_addr_i;
        data1_d = mc_data_i;
      end
    end

    if (pipe_we_i) begin
      we_d    = |pipe_addr_i;
      waddr_d = pipe_addr_i;
      wdata_d = pipe_data_i;
    end else if (pop) begin
      we_d       = |addr0_q;
      waddr_d    = addr0_q;
      wdata_d    = data0_q;
      fifo_src_d = 1'b1;
    end

    // Clear applies on the commit edge; a same-edge issue to that register re-sets it.
    if (fifo_src_q) pending_d[waddr_q] = 1'b0;
    if (iss_valid_i && !pending_q[iss_addr_i] && (iss_addr_i != 5'd0))
      pending_d[iss_addr_i] = 1'b1;

    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q != CW'(STARVE_LIMIT)) begin
      wait_d = wait_q + CW'(1);
    end

    if (pop) hold_d = 1'b0;
    else if (wait_d == CW'(STARVE_LIMIT)) hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      cnt_q      <= '0;
      addr0_q    <= '0;
      data0_q    <= '0;
      addr1_q    <= '0;
      data1_q    <= '0;
      pending_q  <= '0;
      wait_q     <= '0;
      hold_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      fifo_src_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr0_q    <= addr0_d;
      data0_q    <= data0_d;
      addr1_q    <= addr1_d;
      data1_q    <= data1_d;
      pending_q  <= pending_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      fifo_src_q <= fifo_src_d;
    end
  end

  assign mc_ready_o  = (cnt_q != 2'd2);
  assign iss_ready_o = ~pending_q[iss_addr_i];
  assign stall_o     = pending_q[rd_addr1_i] | pending_q[rd_addr2_i];
  assign hold_o      = hold_q;
  assign rf_we_o     = we_q;
  assign rf_w_addr_o = waddr_q;
  assign rf_w_data_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized checks of rf_wb_arbiter against a queue-based model.
`default_nettype none

module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_addr = '0;
  logic [31:0] mc_data = '0;
  logic        mc_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        iss_ready;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        stall, hold, rf_we;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rstd(rstd),
    .pipe_we_i(pipe_we), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .mc_valid_i(mc_valid), .mc_addr_i(mc_addr), .mc_data_i(mc_data), .mc_ready_o(mc_ready),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .iss_ready_o(iss_ready),
    .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2), .stall_o(stall), .hold_o(hold),
    .rf_we_o(rf_we), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  bit   [31:0] mpend;
  int          mwait;
  bit          mhold, mwe, msrc, mvalid;
  logic [4:0]  maddr;
  logic [31:0] mdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpend = '0; mwait = 0; mhold = 0; mwe = 0; msrc = 0; maddr = '0; mdata = '0;
  endtask

  task automatic compare_all();
    chk("mc_ready", 32'(mc_ready), 32'(mq.size() < 2));
    chk("iss_ready", 32'(iss_ready), 32'(!mpend[iss_addr]));
    chk("stall", 32'(stall), 32'(mpend[rd_addr1] | mpend[rd_addr2]));
    chk("hold", 32'(hold), 32'(mhold));
    chk("rf_we", 32'(rf_we), 32'(mwe));
    if (mwe) begin
      chk("rf_w_addr", 32'(rf_w_addr), 32'(maddr));
      chk("rf_w_data", rf_w_data, mdata);
    end
  endtask

  // Applies one clock edge of the spec's rules to the model, using the inputs seen at that edge.
  task automatic model_step();
    int   sz;
    bit   push, pop, setb;
    ent_t h;
    sz   = mq.size();
    push = mc_valid && (sz < 2);
    pop  = !pipe_we && (sz > 0);
    setb = iss_valid && (iss_addr != 0) && !mpend[iss_addr];
    if (msrc) mpend[maddr] = 1'b0;
    if (setb) mpend[iss_addr] = 1'b1;
    if (pipe_we) begin
      mwe = (pipe_addr != 0); maddr = pipe_addr; mdata = pipe_data; msrc = 0;
    end else if (pop) begin
      h = mq.pop_front();
      mwe = (h.a != 0); maddr = h.a; mdata = h.d; msrc = 1;
    end else begin
      mwe = 0; msrc = 0;
    end
    if (pop || sz == 0) mwait = 0;
    else if (pipe_we && mwait < LIMIT) mwait++;
    if (pop) mhold = 0;
    else if (mwait >= LIMIT) mhold = 1;
    if (push) mq.push_back('{a: mc_addr, d: mc_data});
  endtask

  task automatic cyc();
    #1;
    if (mvalid) compare_all();
    @(posedge clk);
    if (rstd) begin
      model_reset();
      mvalid = 1;
    end else if (mvalid) begin
      model_step();
    end
    @(negedge clk);
  endtask

  initial begin
    mvalid = 0;
    model_reset();
    @(negedge clk);
    cyc();
    rstd = 1'b0;
    #1;
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst rf_w_addr", 32'(rf_w_addr), 32'd0);
    chk("rst rf_w_data", rf_w_data, 32'd0);
    chk("rst mc_ready", 32'(mc_ready), 32'd1);
    chk("rst iss_ready", 32'(iss_ready), 32'd1);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst hold", 32'(hold), 32'd0);

    // Pipeline-only write
    pipe_we = 1; pipe_addr = 5; pipe_data = 32'hDEADBEEF;
    cyc();
    pipe_we = 0; #1;
    chk("pipe rf_we", 32'(rf_we), 32'd1);
    chk("pipe addr", 32'(rf_w_addr), 32'd5);
    chk("pipe data", rf_w_data, 32'hDEADBEEF);

    // r0 drop
    pipe_we = 1; pipe_addr = 0; pipe_data = 32'h55;
    cyc();
    pipe_we = 0; #1;
    chk("r0 rf_we", 32'(rf_we), 32'd0);
    iss_valid = 1; iss_addr = 0;
    cyc();
    iss_valid = 0; rd_addr1 = 0; #1;
    chk("r0 stall", 32'(stall), 32'd0);

    // Scoreboard round-trip on r7
    iss_valid = 1; iss_addr = 7;
    cyc();
    iss_valid = 0; rd_addr1 = 7; #1;
    chk("sb stall set", 32'(stall), 32'd1);
    chk("sb iss_ready", 32'(iss_ready), 32'd0);
    repeat (3) cyc();
    mc_valid = 1; mc_addr = 7; mc_data = 32'h1234;
    cyc();
    mc_valid = 0;
    cyc();
    #1;
    chk("sb rf_we", 32'(rf_we), 32'd1);
    chk("sb addr", 32'(rf_w_addr), 32'd7);
    chk("sb data", rf_w_data, 32'h1234);
    chk("sb stall commit cyc", 32'(stall), 32'd1);
    cyc();
    #1;
    chk("sb stall clear", 32'(stall), 32'd0);
    rd_addr1 = 0;

    // Arbitration and full FIFO
    pipe_we = 1; pipe_addr = 9; pipe_data = 32'h99;
    mc_valid = 1; mc_addr = 3; mc_data = 32'hA3;
    cyc();
    mc_addr = 4; mc_data = 32'hB4;
    cyc();
    mc_valid = 0; #1;
    chk("full mc_ready", 32'(mc_ready), 32'd0);
    cyc();
    pipe_we = 0;
    cyc();
    #1;
    chk("pop1 addr", 32'(rf_w_addr), 32'd3);
    chk("pop1 data", rf_w_data, 32'hA3);
    chk("pop1 mc_ready", 32'(mc_ready), 32'd1);
    cyc();
    #1;
    chk("pop2 addr", 32'(rf_w_addr), 32'd4);
    chk("pop2 data", rf_w_data, 32'hB4);

    // Starvation
    pipe_we = 1; pipe_addr = 10; pipe_data = 32'h10;
    mc_valid = 1; mc_addr = 6; mc_data = 32'h66;
    cyc();
    mc_valid = 0;
    repeat (3) cyc();
    #1;
    chk("starve hold early", 32'(hold), 32'd0);
    cyc();
    #1;
    chk("starve hold", 32'(hold), 32'd1);
    pipe_we = 0;
    cyc();
    #1;
    chk("starve hold fall", 32'(hold), 32'd0);
    chk("starve commit addr", 32'(rf_w_addr), 32'd6);

    // Reset mid-flight
    pipe_we = 1; pipe_addr = 12; pipe_data = 32'hC;
    iss_valid = 1; iss_addr = 3; mc_valid = 1; mc_addr = 3; mc_data = 32'h33;
    cyc();
    iss_addr = 4; mc_addr = 4; mc_data = 32'h44;
    cyc();
    iss_valid = 0; mc_valid = 0; rd_addr1 = 3; rd_addr2 = 4; #1;
    chk("mid stall", 32'(stall), 32'd1);
    chk("mid mc_ready", 32'(mc_ready), 32'd0);
    rstd = 1; pipe_we = 0;
    cyc();
    rstd = 0; #1;
    chk("post rst mc_ready", 32'(mc_ready), 32'd1);
    chk("post rst stall", 32'(stall), 32'd0);
    chk("post rst rf_we", 32'(rf_we), 32'd0);
    chk("post rst hold", 32'(hold), 32'd0);
    cyc();
    #1;
    chk("post rst no pop", 32'(rf_we), 32'd0);
    rd_addr1 = 0; rd_addr2 = 0;

    // Randomized traffic over a narrow address range to force collisions
    for (int i = 0; i < 3000; i++) begin
      pipe_we   = ($urandom_range(99) < 50) && !(hold && $urandom_range(99) < 80);
      pipe_addr = 5'($urandom_range(7));
      pipe_data = $urandom;
      mc_valid  = ($urandom_range(99) < 40);
      mc_addr   = 5'($urandom_range(7));
      mc_data   = $urandom;
      iss_valid = ($urandom_range(99) < 30);
      iss_addr  = 5'($urandom_range(7));
      rd_addr1  = 5'($urandom_range(7));
      rd_addr2  = 5'($urandom_range(7));
      rstd      = ($urandom_range(499) == 0);
      cyc();
    end
    rstd = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
